video_sink: RTL and testbench
=============================

# video_sink

Receiving end of the core's video store interface. Captures every store the core makes into the video address window, writes the pixel into an internal dual-port framebuffer, and streams the framebuffer out in raster order with blanking and frame markers for a display or capture model. It never back-pressures the core, because the core cannot stall on video stores. Out-of-window, misaligned, and clear-phase writes are counted and dropped.

## Interface
- BASE_ADDR, 32'h00008000, byte address of pixel (0,0)
- H_ACTIVE, 64, visible pixels per line
- H_TOTAL, 80, clocks per line, including blanking; must be greater than H_ACTIVE
- V_ACTIVE, 48, visible lines per frame
- V_TOTAL, 52, lines per frame, including blanking; must be greater than V_ACTIVE
- PIX_W, 24, stored bits per pixel: video_data[PIX_W-1:0]

- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-high
- video_we  in  1  core store strobe into the video range
- video_addr  in  32  byte address of the store
- video_data  in  32  store data
- ready  out  1  high in RUN state
- pix_valid  out  1  pix_data, pix_x and pix_y are a visible pixel
- pix_data  out  PIX_W  pixel value
- pix_x  out  16  column of pix_data
- pix_y  out  16  row of pix_data
- hblank  out  1  scan position is in horizontal blanking
- vblank  out  1  scan position is in vertical blanking
- frame_start  out  1  one-cycle pulse that accompanies pixel (0,0)
- drop_count  out  16  dropped writes; saturates at 16'hFFFF

## Operation
- Framebuffer size: N = H_ACTIVE*V_ACTIVE words of PIX_W bits.
  - One write port and one synchronous read port.
  - Read-before-write: a same-cycle read and write to one address returns the old data.
- FSM has two states: CLEAR and RUN.
  - Reset enters CLEAR with clr_ptr=0.
  - CLEAR writes 0 to address clr_ptr every cycle and increments clr_ptr.
  - When clr_ptr reaches N-1 that cycle writes 0, and the FSM moves to RUN on the next edge. CLEAR lasts exactly N cycles.
  - RUN is held until reset.
- Write accept (RUN only): off = video_addr - BASE_ADDR, with 32-bit unsigned arithmetic. A write is accepted when all of these hold:
  - video_we=1
  - video_addr >= BASE_ADDR
  - off[1:0] == 0
  - (off>>2) < N
- An accepted write stores video_data[PIX_W-1:0] at index off>>2. Row-major order: index = y*H_ACTIVE + x.
- Drops: any video_we=1 cycle that is not accepted increments drop_count by 1. This covers out-of-window, misaligned, and any write during CLEAR. drop_count saturates at 16'hFFFF.
- Scan counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1):
  - They hold at (0,0) during CLEAR and advance every cycle in RUN.
  - h wraps to 0 at H_TOTAL-1 and v increments on that wrap.
  - v wraps to 0 at V_TOTAL-1 when h also wraps.
- Stage 0 (counters):
  - active = (h<H_ACTIVE)&&(v<V_ACTIVE)
  - read index = v*H_ACTIVE+h whenever active
- Stage 1 (registered outputs):
  - pix_valid = active
  - pix_x=h, pix_y=v
  - hblank = (h>=H_ACTIVE), vblank = (v>=V_ACTIVE)
  - frame_start = (h==0&&v==0)
  - pix_data = RAM read data
  - When not active, pix_data is forced to 0.
- Writes are never blocked by scanout. A write to an address already scanned in the current frame appears in the next frame.

## Timing
- Reset values of every output:
  - ready=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0
  - hblank=0, vblank=0, frame_start=0, drop_count=0
  - Internal: h=v=0, clr_ptr=0
  - RAM contents are only defined after CLEAR.
- ready rises at the edge where the FSM enters RUN, N cycles after reset release. Scanning starts at that edge, with (h,v)=(0,0) in the first RUN cycle.
- Scanout latency: position (h,v) appears on the outputs 1 cycle later. The first frame_start pulse is in the 2nd RUN cycle.
- Write-to-read: a write accepted at edge E is visible to any stage-0 read issued after E. A read issued in the same cycle as the write returns the old value.
- A frame is H_TOTAL*V_TOTAL cycles; frame_start repeats with that period.
- Reset asserted mid-frame or mid-CLEAR:
  - All state and outputs return to reset values immediately, without waiting for a clock edge.
  - CLEAR restarts from 0 after release.
- drop_count updates at the edge that samples the dropped write.

## Test plan
- Reset release, no writes:
  - ready rises after exactly 3072 cycles.
  - First frame_start is 1 cycle later, with pix_x=0, pix_y=0, pix_valid=1, pix_data=0.
  - All 3072 visible pixels read back 0.
- Pixel write and readback, in RUN:
  - Store 0x00ABCDEF to 0x8000 and 0x00123456 to 0x8000+4*(47*64+63).
  - The next frame shows pixel (0,0)=0xABCDEF and (63,47)=0x123456.
  - drop_count stays 0.
- Drop cases, in RUN, one each:
  - Stores to 0x7FFC, 0x8002, 0x8000+4*3072, and 0xFFFFFFFC.
  - drop_count=4, and no pixel changes.
- Write during CLEAR: store to 0x8000 at cycle 10 after reset release.
  - Dropped: drop_count=1 and pixel (0,0) is still 0 after CLEAR.
- Blanking and wrap:
  - hblank is high for 16 cycles per line.
  - vblank is high for 4 lines (4*80 cycles).
  - frame_start period is 4160 cycles.
  - pix_valid count per frame is 3072.
- Same-cycle hazard and mid-frame reset:
  - Write pixel (5,0) in the cycle where stage 0 reads (5,0): the old value is output that frame and the new value in the next frame.
  - Assert rst mid-frame: outputs go to 0 before the next clock edge, and ready is low for 3072 cycles after release.

Source files
------------

// File: rtl/video_sink_if.sv
// Core-to-video store bus: a write strobe with byte address and data.
// The sink never back-pressures, so the bus carries no ready or acknowledge.
interface video_sink_if;
  logic        video_we;
  logic [31:0] video_addr;
  logic [31:0] video_data;

  modport master (output video_we, output video_addr, output video_data);
  modport slave  (input  video_we, input  video_addr, input  video_data);
endinterface

// File: rtl/video_sink.sv
// Captures core video stores into a dual-port framebuffer and scans it out in
// raster order with blanking flags and a frame-start marker.
module video_sink #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int          H_ACTIVE  = 64,
  parameter int          H_TOTAL   = 80,
  parameter int          V_ACTIVE  = 48,
  parameter int          V_TOTAL   = 52,
  parameter int          PIX_W     = 24
) (
  input  logic               clk,
  input  logic               rst,
  video_sink_if.slave        bus,
  output logic               ready,
  output logic               pix_valid,
  output logic [PIX_W-1:0]   pix_data,
  output logic [15:0]        pix_x,
  output logic [15:0]        pix_y,
  output logic               hblank,
  output logic               vblank,
  output logic               frame_start,
  output logic [15:0]        drop_count
);

  localparam int N  = H_ACTIVE * V_ACTIVE;
  localparam int AW = $clog2(N);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [AW-1:0] CLR_LAST = AW'(N - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [31:0]   N_W      = 32'(N);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t          state, state_nx;
  logic            clr_en, run;
  logic [AW-1:0]   clr_ptr;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;

  // ---------------- FSM ----------------
  // NOTE: every clocked process uses non-blocking (<=) so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == ST_CLEAR && clr_ptr == CLR_LAST) state_nx = ST_RUN;
  end

  // NOTE: defaults before the case keep these purely combinational (no latch).
  always_comb begin
    ready  = 1'b0;
    clr_en = 1'b0;
    run    = 1'b0;
    case (state)
      ST_CLEAR: clr_en = 1'b1;
      ST_RUN: begin
        ready = 1'b1;
        run   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         clr_ptr <= '0;
    else if (clr_en) clr_ptr <= clr_ptr + 1'b1;
  end

  // ---------------- Store decode ----------------
  logic [31:0]      off;
  logic             in_window, accept, drop;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [PIX_W-1:0] mem_wdata;

  assign off       = bus.video_addr - BASE_ADDR;
  assign in_window = (bus.video_addr >= BASE_ADDR) && (off[1:0] == 2'b00) &&
                     ({2'b00, off[31:2]} < N_W);
  assign accept    = run && bus.video_we && in_window;
  assign drop      = bus.video_we && !accept;

  // The clear sweep and core stores never overlap: stores are only accepted in RUN.
  assign mem_we    = clr_en || accept;
  assign mem_waddr = clr_en ? clr_ptr : off[AW+1:2];
  assign mem_wdata = clr_en ? '0 : bus.video_data[PIX_W-1:0];

  if (PIX_W < 32) begin : g_unused_hi
    logic unused_data_hi;
    assign unused_data_hi = ^bus.video_data[31:PIX_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)    drop_count <= drop_count + 16'd1;
  end

  // ---------------- Scan counters (stage 0) ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  logic          active, rd_en;
  logic [AW-1:0] rd_addr;

  assign active  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign rd_en   = run && active;
  assign rd_addr = AW'(v_cnt) * AW'(H_ACTIVE) + AW'(h_cnt);

  // ---------------- Framebuffer ----------------
  logic [PIX_W-1:0] mem [N];
  logic [PIX_W-1:0] rd_data;

  // NOTE: the array and its read register carry no reset; CLEAR defines contents, pix_valid masks rd_data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en)  rd_data        <= mem[rd_addr];
  end

  // ---------------- Stage 1 outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // During CLEAR the counters sit at (0,0); gating keeps valid/frame_start quiet.
      pix_valid   <= run && active;
      pix_x       <= 16'(h_cnt);
      pix_y       <= 16'(v_cnt);
      hblank      <= h_cnt >= H_ACT_C;
      vblank      <= v_cnt >= V_ACT_C;
      frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign pix_data = pix_valid ? rd_data : '0;

endmodule

// File: tb/tb_video_sink.sv
// Directed bench for video_sink: clear timing, store table, scan geometry,
// same-cycle read/write hazard and asynchronous mid-frame reset.
module tb_video_sink;

  localparam int H_ACTIVE = 64;
  localparam int H_TOTAL  = 80;
  localparam int V_ACTIVE = 48;
  localparam int V_TOTAL  = 52;
  localparam int N        = H_ACTIVE * V_ACTIVE;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready, pix_valid, hblank, vblank, frame_start;
  logic [23:0] pix_data;
  logic [15:0] pix_x, pix_y, drop_count;

  video_sink_if vif ();

  video_sink #(
    .BASE_ADDR (32'h0000_8000),
    .H_ACTIVE  (H_ACTIVE),
    .H_TOTAL   (H_TOTAL),
    .V_ACTIVE  (V_ACTIVE),
    .V_TOTAL   (V_TOTAL),
    .PIX_W     (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (vif.slave),
    .ready       (ready),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hblank      (hblank),
    .vblank      (vblank),
    .frame_start (frame_start),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  logic [23:0] fb_model [N];
  logic [23:0] fb_cap   [N];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_acc;
    int          exp_idx;
    int          exp_drop;
  } wr_vec_t;

  wr_vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, {27'd0, ready, pix_valid, hblank, vblank, frame_start}, 32'd0);
    check({tag, "_pix_data"}, {8'd0, pix_data}, 32'd0);
    check({tag, "_pix_x"}, {16'd0, pix_x}, 32'd0);
    check({tag, "_pix_y"}, {16'd0, pix_y}, 32'd0);
    check({tag, "_drop_count"}, {16'd0, drop_count}, 32'd0);
  endtask

  // Called at a negedge right after rst is released; optionally injects one store at cycle inject.
  task automatic run_clear(input int inject);
    int early;
    early = 0;
    for (int n = 1; n <= N; n++) begin
      vif.video_we   = (n == inject);
      vif.video_addr = 32'h0000_8000;
      vif.video_data = 32'h00FF_FFFF;
      @(posedge clk); #1;
      if (n < N && ready) early++;
      @(negedge clk);
    end
    vif.video_we = 1'b0;
    check("ready_early", early, 0);
    check("ready_at_N", {31'd0, ready}, 32'd1);
    check("clear_drops", {16'd0, drop_count}, (inject > 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check("first_fs", {28'd0, frame_start, pix_valid, hblank, vblank}, 32'b1100);
    check("first_xy", {pix_x, pix_y}, 32'd0);
    check("first_data", {8'd0, pix_data}, 32'd0);
  endtask

  task automatic write_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    vif.video_we   = 1'b1;
    vif.video_addr = addr;
    vif.video_data = data;
    @(negedge clk);
    vif.video_we   = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(posedge clk); #1;
      if (frame_start) ok = 1'b1;
    end
    if (!ok) check("fs_timeout", 32'd0, 32'd1);
  endtask

  // Samples one full frame starting at a frame_start pulse and checks geometry and contents.
  task automatic capture();
    bit ok;
    int bad_scan, nvalid, nh, nv, bad_lines, mism, x, y;
    int hb_line [V_TOTAL];
    wait_fs(ok);
    if (!ok) return;
    bad_scan = 0; nvalid = 0; nh = 0; nv = 0; bad_lines = 0; mism = 0;
    foreach (hb_line[k]) hb_line[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      x = i % H_TOTAL;
      y = i / H_TOTAL;
      if (pix_x != 16'(x) || pix_y != 16'(y)) bad_scan++;
      if (pix_valid != (x < H_ACTIVE && y < V_ACTIVE)) bad_scan++;
      if (hblank != (x >= H_ACTIVE) || vblank != (y >= V_ACTIVE)) bad_scan++;
      if (frame_start != (i == 0)) bad_scan++;
      if (!pix_valid && pix_data != 24'd0) bad_scan++;
      if (pix_valid) nvalid++;
      if (pix_valid && x < H_ACTIVE && y < V_ACTIVE) fb_cap[y*H_ACTIVE + x] = pix_data;
      if (hblank) begin
        nh++;
        hb_line[y]++;
      end
      if (vblank) nv++;
    end
    @(posedge clk); #1;
    check("fs_period", {31'd0, frame_start}, 32'd1);
    foreach (hb_line[k]) if (hb_line[k] != H_TOTAL - H_ACTIVE) bad_lines++;
    check("scan_pattern", bad_scan, 0);
    check("valid_count", nvalid, N);
    check("hblank_lines", bad_lines, 0);
    check("hblank_total", nh, (H_TOTAL - H_ACTIVE) * V_TOTAL);
    check("vblank_total", nv, (V_TOTAL - V_ACTIVE) * H_TOTAL);
    foreach (fb_model[k]) if (fb_cap[k] !== fb_model[k]) mism++;
    check("fb_contents", mism, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;

    vecs[0] = '{32'h0000_8000, 32'h00AB_CDEF, 1'b1, 0,    0};
    vecs[1] = '{32'h0000_AFFC, 32'h0012_3456, 1'b1, 3071, 0};
    vecs[2] = '{32'h0000_8004, 32'hFF65_4321, 1'b1, 1,    0};
    vecs[3] = '{32'h0000_7FFC, 32'h0011_1111, 1'b0, 0,    1};
    vecs[4] = '{32'h0000_8002, 32'h0022_2222, 1'b0, 0,    2};
    vecs[5] = '{32'h0000_B000, 32'h0033_3333, 1'b0, 0,    3};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0044_4444, 1'b0, 0,    4};

    vif.video_we   = 1'b0;
    vif.video_addr = '0;
    vif.video_data = '0;
    foreach (fb_model[k]) fb_model[k] = '0;

    // Reset state, clear timing, first frame all zero.
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    run_clear(0);
    capture();

    // Store table: accepted stores land in the model, drops only bump the counter.
    foreach (vecs[i]) begin
      write_store(vecs[i].addr, vecs[i].data);
      check($sformatf("drop_count_v%0d", i), {16'd0, drop_count}, vecs[i].exp_drop);
      if (vecs[i].exp_acc) fb_model[vecs[i].exp_idx] = vecs[i].data[23:0];
    end
    capture();
    check("pix_0_0", {8'd0, fb_cap[0]}, 32'h00AB_CDEF);
    check("pix_63_47", {8'd0, fb_cap[N-1]}, 32'h0012_3456);
    check("pix_1_0_trunc", {8'd0, fb_cap[1]}, 32'h0065_4321);

    // Store to (5,0) during the very cycle stage 0 reads (5,0).
    wait_fs(ok);
    if (ok) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      vif.video_we   = 1'b1;
      vif.video_addr = 32'h0000_8014;
      vif.video_data = 32'h005A_5A5A;
      @(posedge clk); #1;
      check("hazard_xy", {pix_x, pix_y}, {16'd5, 16'd0});
      check("hazard_old", {8'd0, pix_data}, 32'd0);
      @(negedge clk);
      vif.video_we = 1'b0;
      fb_model[5] = 24'h5A5A5A;
      capture();
      check("hazard_new", {8'd0, fb_cap[5]}, 32'h005A_5A5A);
    end

    // Asynchronous reset mid-frame, then a store during the restarted CLEAR.
    repeat (1000) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    foreach (fb_model[k]) fb_model[k] = '0;
    run_clear(10);
    capture();
    check("clear_write_pix", {8'd0, fb_cap[0]}, 32'd0);
    check("drop_after_clear", {16'd0, drop_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end

endmodule
